// File: rtl/code_line_fetch_if.sv
// Handshake and bus bundle for the instruction-line fetch sequencer:
// icache request side, readcode burst side, snoop side and line result.
interface code_line_fetch_if;
   logic         fetch_req;
   logic [31:0]  fetch_addr;
   logic         fetch_ack;
   logic         busy;
   logic         readcode_do;
   logic [31:0]  readcode_address;
   logic         readcode_done;
   logic [31:0]  readcode_partial;
   logic         word_valid;
   logic [2:0]   word_index;
   logic [31:0]  word_data;
   logic         line_valid;
   logic         line_stale;
   logic [26:0]  line_addr;
   logic [255:0] line_data;
   logic         snoop_we;
   logic [25:0]  snoop_addr;

   modport slave (
      input  fetch_req, fetch_addr,
      input  readcode_done, readcode_partial,
      input  snoop_we, snoop_addr,
      output fetch_ack, busy,
      output readcode_do, readcode_address,
      output word_valid, word_index, word_data,
      output line_valid, line_stale, line_addr, line_data
   );

   modport master (
      output fetch_req, fetch_addr,
      output readcode_done, readcode_partial,
      output snoop_we, snoop_addr,
      input  fetch_ack, busy,
      input  readcode_do, readcode_address,
      input  word_valid, word_index, word_data,
      input  line_valid, line_stale, line_addr, line_data
   );
endinterface

// File: rtl/code_line_fetch.sv
// Instruction-line fetch sequencer: one 8-dword readcode burst per icache
// line fill, early per-beat forwarding and snoop-driven stale flagging.
module code_line_fetch #(
   parameter int LINE_DWORDS = 8
) (
   input logic               clk,
   input logic               rst_n,
   code_line_fetch_if.slave  bus
);

   localparam logic [2:0] LAST = 3'(LINE_DWORDS - 1);

   typedef enum logic [1:0] {IDLE, REQ, BURST, DONE} state_t;

   state_t     state;
   logic [2:0] count;
   logic       stale;
   logic       accept;
   logic       beat;
   logic       hit;
   logic       hit_new;
   logic       unused;

   assign unused = ^{bus.fetch_addr[4:0], bus.snoop_addr[2:0]};

   assign accept = (state == IDLE) && bus.fetch_req;
   assign beat   = ((state == REQ) || (state == BURST)) && bus.readcode_done;

   // Only the low 256 MB is snooped, hence the upper-nibble qualifier.
   assign hit_new = bus.snoop_we
                 && (bus.snoop_addr[25:3] == bus.fetch_addr[27:5])
                 && (bus.fetch_addr[31:28] == 4'h0);
   assign hit     = bus.snoop_we
                 && (bus.snoop_addr[25:3] == bus.line_addr[22:0])
                 && (bus.line_addr[26:23] == 4'h0);

   assign bus.fetch_ack = accept;
   assign bus.busy      = (state != IDLE);

   assign bus.readcode_address =
      accept   ? {bus.fetch_addr[31:5], 5'b0} :
      bus.busy ? {bus.line_addr, 5'b0}        :
                 32'h0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state           <= IDLE;
         count           <= 3'd0;
         stale           <= 1'b0;
         bus.readcode_do <= 1'b0;
         bus.word_valid  <= 1'b0;
         bus.word_index  <= 3'd0;
         bus.word_data   <= 32'h0;
         bus.line_valid  <= 1'b0;
         bus.line_stale  <= 1'b0;
      end else begin
         bus.word_valid <= beat;
         bus.line_valid <= 1'b0;
         bus.line_stale <= 1'b0;
         if (beat) begin
            bus.word_index <= count;
            bus.word_data  <= bus.readcode_partial;
            bus.line_data[{count, 5'b0} +: 32] <= bus.readcode_partial;
         end
         unique case (state)
            IDLE: begin
               if (bus.fetch_req) begin
                  bus.line_addr   <= bus.fetch_addr[31:5];
                  count           <= 3'd0;
                  stale           <= hit_new;
                  bus.readcode_do <= 1'b1;
                  state           <= REQ;
               end
            end
            REQ: begin
               stale <= stale | hit;
               if (bus.readcode_done) begin
                  count           <= 3'd1;
                  bus.readcode_do <= 1'b0;
                  state           <= BURST;
               end
            end
            BURST: begin
               stale <= stale | hit;
               if (bus.readcode_done) begin
                  if (count == LAST) begin
                     bus.line_valid <= 1'b1;
                     bus.line_stale <= stale | hit;
                     state          <= DONE;
                  end else begin
                     count <= count + 3'd1;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_code_line_fetch.sv
// Directed bench for code_line_fetch: reset, fills with and without gaps,
// snoop hit/miss cases, reset mid-burst and back-to-back fills.
module tb_code_line_fetch;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   code_line_fetch_if bus ();

   code_line_fetch dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int tests = 0;
   int fails = 0;

   int           ob_ack_to;
   int           ob_addr_err;
   int           ob_rdo_err;
   int           ob_idx_err;
   logic         ob_lv;
   logic         ob_stale;
   logic         ob_lv_after;
   logic         ob_busy_after;
   logic [26:0]  ob_laddr;
   logic [255:0] ob_line;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Runs one fill; snoop_at: 99 none, -1 accept cycle, 0..7 beat, 8 DONE.
   task automatic do_fill(input logic [31:0] addr, input logic [31:0] base,
                          input int gap_max, input int snoop_at,
                          input logic [25:0] saddr);
      bit          acked;
      int          g;
      logic [31:0] exp_ra;
      exp_ra        = {addr[31:5], 5'b0};
      ob_ack_to     = 0;
      ob_addr_err   = 0;
      ob_rdo_err    = 0;
      ob_idx_err    = 0;
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = addr;
      bus.snoop_we   = (snoop_at == -1);
      bus.snoop_addr = saddr;
      acked = 1'b0;
      for (int n = 0; n < 20 && !acked; n++) begin
         #1;
         if (bus.fetch_ack === 1'b1) acked = 1'b1;
         else step();
      end
      if (!acked) ob_ack_to = 1;
      if (bus.readcode_address !== exp_ra) ob_addr_err++;
      step();
      bus.fetch_req = 1'b0;
      bus.snoop_we  = 1'b0;
      for (int b = 0; b < 8; b++) begin
         g = int'($urandom_range(gap_max, 0));
         for (int i = 0; i < g; i++) begin
            if (bus.readcode_do !== (b == 0)) ob_rdo_err++;
            if (bus.readcode_address !== exp_ra) ob_addr_err++;
            step();
         end
         if (bus.readcode_do !== (b == 0)) ob_rdo_err++;
         if (bus.readcode_address !== exp_ra) ob_addr_err++;
         bus.readcode_done    = 1'b1;
         bus.readcode_partial = base + 32'(b);
         bus.snoop_we         = (snoop_at == b);
         step();
         bus.readcode_done = 1'b0;
         bus.snoop_we      = 1'b0;
         if (bus.word_valid !== 1'b1 || bus.word_index !== 3'(b)
             || bus.word_data !== base + 32'(b)) ob_idx_err++;
         if (b < 7 && bus.line_valid !== 1'b0) ob_idx_err++;
      end
      if (bus.readcode_do !== 1'b0) ob_rdo_err++;
      if (bus.readcode_address !== exp_ra) ob_addr_err++;
      ob_lv    = bus.line_valid;
      ob_stale = bus.line_stale;
      ob_line  = bus.line_data;
      ob_laddr = bus.line_addr;
      bus.snoop_we = (snoop_at == 8);
      step();
      bus.snoop_we  = 1'b0;
      ob_lv_after   = bus.line_valid;
      ob_busy_after = bus.busy;
   endtask

   task automatic test_reset();
      bus.fetch_req        = 1'b0;
      bus.fetch_addr       = 32'h0;
      bus.readcode_done    = 1'b0;
      bus.readcode_partial = 32'h0;
      bus.snoop_we         = 1'b0;
      bus.snoop_addr       = 26'h0;
      rst_n = 1'b0;
      step();
      step();
      tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      tests++; if (bus.readcode_do !== 1'b0) begin fails++; $display("FAIL reset_rdo: got %b want 0", bus.readcode_do); end
      tests++; if (bus.fetch_ack !== 1'b0) begin fails++; $display("FAIL reset_ack: got %b want 0", bus.fetch_ack); end
      tests++; if ({bus.word_valid, bus.line_valid, bus.line_stale} !== 3'b000) begin fails++; $display("FAIL reset_valids: got %b want 000", {bus.word_valid, bus.line_valid, bus.line_stale}); end
      tests++; if (bus.readcode_address !== 32'h0) begin fails++; $display("FAIL reset_raddr: got %h want 0", bus.readcode_address); end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_basic_fill();
      logic [255:0] exp_line;
      for (int i = 0; i < 8; i++) exp_line[32*i +: 32] = 32'hA0 + 32'(i);
      do_fill(32'h0001_23A7, 32'hA0, 0, 99, 26'h0);
      tests++; if (ob_ack_to !== 0) begin fails++; $display("FAIL basic_ack: got timeout want ack"); end
      tests++; if (ob_addr_err !== 0) begin fails++; $display("FAIL basic_raddr: got %0d errs want 0 (addr 000123a0)", ob_addr_err); end
      tests++; if (ob_rdo_err !== 0) begin fails++; $display("FAIL basic_rdo: got %0d errs want 0", ob_rdo_err); end
      tests++; if (ob_idx_err !== 0) begin fails++; $display("FAIL basic_words: got %0d errs want 0", ob_idx_err); end
      tests++; if (ob_lv !== 1'b1) begin fails++; $display("FAIL basic_line_valid: got %b want 1", ob_lv); end
      tests++; if (ob_stale !== 1'b0) begin fails++; $display("FAIL basic_stale: got %b want 0", ob_stale); end
      tests++; if (ob_line[31:0] !== 32'hA0) begin fails++; $display("FAIL basic_dw0: got %h want a0", ob_line[31:0]); end
      tests++; if (ob_line[255:224] !== 32'hA7) begin fails++; $display("FAIL basic_dw7: got %h want a7", ob_line[255:224]); end
      tests++; if (ob_line !== exp_line) begin fails++; $display("FAIL basic_line: got %h want %h", ob_line, exp_line); end
      tests++; if (ob_laddr !== 27'h91D) begin fails++; $display("FAIL basic_laddr: got %h want 91d", ob_laddr); end
      tests++; if ({ob_lv_after, ob_busy_after} !== 2'b00) begin fails++; $display("FAIL basic_after: got %b want 00", {ob_lv_after, ob_busy_after}); end
   endtask

   task automatic test_gaps();
      logic [255:0] exp_line;
      for (int i = 0; i < 8; i++) exp_line[32*i +: 32] = 32'h5000_0000 + 32'(i);
      for (int r = 0; r < 3; r++) begin
         do_fill(32'h00AB_C000, 32'h5000_0000, 5, 99, 26'h0);
         tests++; if (ob_idx_err !== 0) begin fails++; $display("FAIL gaps_words: got %0d errs want 0", ob_idx_err); end
         tests++; if (ob_rdo_err !== 0) begin fails++; $display("FAIL gaps_rdo: got %0d errs want 0", ob_rdo_err); end
         tests++; if (ob_addr_err !== 0) begin fails++; $display("FAIL gaps_raddr: got %0d errs want 0", ob_addr_err); end
         tests++; if (ob_lv !== 1'b1 || ob_line !== exp_line) begin fails++; $display("FAIL gaps_line: got lv=%b %h want lv=1 %h", ob_lv, ob_line, exp_line); end
      end
   endtask

   task automatic test_snoop_hit();
      do_fill(32'h0001_23A0, 32'hC0, 2, 3, 26'h00048E8);
      tests++; if ({ob_lv, ob_stale} !== 2'b11) begin fails++; $display("FAIL snoop_burst: got lv,stale=%b want 11", {ob_lv, ob_stale}); end
      do_fill(32'h0001_23A0, 32'hC0, 0, 7, 26'h00048EF);
      tests++; if ({ob_lv, ob_stale} !== 2'b11) begin fails++; $display("FAIL snoop_last: got lv,stale=%b want 11", {ob_lv, ob_stale}); end
      do_fill(32'h0001_23A0, 32'hC0, 1, -1, 26'h00048E8);
      tests++; if ({ob_lv, ob_stale} !== 2'b11) begin fails++; $display("FAIL snoop_accept: got lv,stale=%b want 11", {ob_lv, ob_stale}); end
   endtask

   task automatic test_snoop_miss();
      do_fill(32'h1001_23A0, 32'hE0, 1, 3, 26'h00048E8);
      tests++; if ({ob_lv, ob_stale} !== 2'b10) begin fails++; $display("FAIL snoop_hi: got lv,stale=%b want 10", {ob_lv, ob_stale}); end
      do_fill(32'h0001_23A0, 32'hE0, 1, 8, 26'h00048E8);
      tests++; if ({ob_lv, ob_stale} !== 2'b10) begin fails++; $display("FAIL snoop_done: got lv,stale=%b want 10", {ob_lv, ob_stale}); end
      do_fill(32'h0001_23A0, 32'hE0, 0, 2, 26'h00048F0);
      tests++; if ({ob_lv, ob_stale} !== 2'b10) begin fails++; $display("FAIL snoop_other: got lv,stale=%b want 10", {ob_lv, ob_stale}); end
      do_fill(32'h0001_23A0, 32'hE0, 0, 99, 26'h0);
      tests++; if ({ob_lv, ob_stale} !== 2'b10) begin fails++; $display("FAIL snoop_cleared: got lv,stale=%b want 10", {ob_lv, ob_stale}); end
   endtask

   task automatic test_reset_mid();
      bit acked;
      int nlv;
      int nwv;
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 32'h0000_2000;
      acked = 1'b0;
      for (int n = 0; n < 20 && !acked; n++) begin
         #1;
         if (bus.fetch_ack === 1'b1) acked = 1'b1;
         else step();
      end
      tests++; if (!acked) begin fails++; $display("FAIL rstmid_ack: got timeout want ack"); end
      step();
      bus.fetch_req = 1'b0;
      for (int b = 0; b < 3; b++) begin
         bus.readcode_done    = 1'b1;
         bus.readcode_partial = 32'hD0 + 32'(b);
         step();
      end
      bus.readcode_done = 1'b0;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
      tests++; if (bus.readcode_do !== 1'b0) begin fails++; $display("FAIL rstmid_rdo: got %b want 0", bus.readcode_do); end
      tests++; if (bus.line_valid !== 1'b0) begin fails++; $display("FAIL rstmid_lv: got %b want 0", bus.line_valid); end
      tests++; if (bus.line_data[31:0] !== 32'hD0) begin fails++; $display("FAIL rstmid_hold_data: got %h want d0", bus.line_data[31:0]); end
      tests++; if (bus.line_addr !== 27'h100) begin fails++; $display("FAIL rstmid_hold_addr: got %h want 100", bus.line_addr); end
      nlv = 0;
      nwv = 0;
      bus.readcode_done = 1'b1;
      for (int c = 0; c < 12; c++) begin
         step();
         if (bus.line_valid === 1'b1) nlv++;
         if (bus.word_valid === 1'b1) nwv++;
      end
      bus.readcode_done = 1'b0;
      tests++; if (nlv !== 0 || nwv !== 0) begin fails++; $display("FAIL rstmid_idle_done: got lv=%0d wv=%0d want 0 0", nlv, nwv); end
   endtask

   task automatic test_back_to_back();
      int a1, a2, l1, l2, nack, nwv;
      a1 = -1; a2 = -1; l1 = -1; l2 = -1;
      nack = 0;
      nwv  = 0;
      bus.fetch_req     = 1'b1;
      bus.fetch_addr    = 32'h0004_0040;
      bus.readcode_done = 1'b1;
      for (int c = 0; c < 60 && l2 < 0; c++) begin
         bus.readcode_partial = 32'(c);
         #1;
         if (bus.fetch_ack === 1'b1) begin
            nack++;
            if (a1 < 0) a1 = c; else if (a2 < 0) a2 = c;
         end
         if (bus.word_valid === 1'b1) nwv++;
         if (bus.line_valid === 1'b1) begin
            if (l1 < 0) l1 = c; else l2 = c;
         end
         if (l2 < 0) step();
      end
      bus.fetch_req     = 1'b0;
      bus.readcode_done = 1'b0;
      tests++; if (l2 < 0) begin fails++; $display("FAIL b2b_timeout: got no second line_valid want one"); end
      tests++; if (nack !== 2) begin fails++; $display("FAIL b2b_acks: got %0d want 2", nack); end
      tests++; if (a2 - l1 !== 1) begin fails++; $display("FAIL b2b_gap: got %0d want 1", a2 - l1); end
      tests++; if (a2 - a1 !== 10) begin fails++; $display("FAIL b2b_period: got %0d want 10", a2 - a1); end
      tests++; if (l1 - a1 !== 9) begin fails++; $display("FAIL b2b_latency: got %0d want 9", l1 - a1); end
      tests++; if (nwv !== 16) begin fails++; $display("FAIL b2b_words: got %0d want 16", nwv); end
      step();
      tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL b2b_idle: got %b want 0", bus.busy); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic_fill();
      test_gaps();
      test_snoop_hit();
      test_snoop_miss();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
